// File: rtl/dl_pipe_reg_vr.sv
// Multi-stage valid/ready pipeline register with bubble collapsing, flush and occupancy count.
// Define DL_PIPE_REG_VR_SKID_EN to add a one-entry skid buffer that registers in_rdy.
module dl_pipe_reg_vr #(
  parameter int unsigned          NUM_BITS   = 32,
  parameter int unsigned          NUM_STAGES = 2,
  parameter logic [NUM_BITS-1:0]  RST_DATA   = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              in_vld,
  output logic                              in_rdy,
  input  logic [NUM_BITS-1:0]               in_data,
  output logic                              out_vld,
  input  logic                              out_rdy,
  output logic [NUM_BITS-1:0]               out_data,
  output logic [$clog2(NUM_STAGES+2)-1:0]   count
);

  localparam int unsigned CntW = $clog2(NUM_STAGES + 2);

  logic [NUM_STAGES-1:0]               vld_q, vld_d;
  logic [NUM_STAGES-1:0][NUM_BITS-1:0] data_q, data_d;
  logic [NUM_STAGES-1:0]               rdy;
  logic [NUM_STAGES-1:0]               src_vld;
  logic [NUM_STAGES-1:0][NUM_BITS-1:0] src_data;
  logic                                src0_vld;
  logic [NUM_BITS-1:0]                 src0_data;
  logic                                accept, consume;
  logic [CntW-1:0]                     count_q, count_d;

  // Ready ripples back from the output; a chain variable avoids a self-referencing vector.
  always_comb begin : p_rdy
    logic chain;
    chain = out_rdy;
    rdy   = '0;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      chain  = !vld_q[i] | chain;
      rdy[i] = chain;
    end
  end

`ifdef DL_PIPE_REG_VR_SKID_EN
  logic                skid_vld_q, skid_vld_d;
  logic [NUM_BITS-1:0] skid_data_q, skid_data_d;

  assign in_rdy    = !skid_vld_q;
  assign src0_vld  = skid_vld_q | in_vld;
  assign src0_data = skid_vld_q ? skid_data_q : in_data;

  // While the skid is full in_rdy is low, so it only ever drains; otherwise it catches
  // an accepted word that stage 0 cannot take this cycle.
  always_comb begin
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    if (skid_vld_q) begin
      if (rdy[0]) skid_vld_d = 1'b0;
    end else if (in_vld && !rdy[0]) begin
      skid_vld_d  = 1'b1;
      skid_data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_vld_q  <= 1'b0;
      skid_data_q <= RST_DATA;
    end else if (flush) begin
      skid_vld_q  <= 1'b0;
    end else begin
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
    end
  end
`else
  assign in_rdy    = rdy[0];
  assign src0_vld  = in_vld;
  assign src0_data = in_data;
`endif

  always_comb begin
    src_vld     = '0;
    src_data    = '0;
    src_vld[0]  = src0_vld;
    src_data[0] = src0_data;
    for (int i = 1; i < int'(NUM_STAGES); i++) begin
      src_vld[i]  = vld_q[i-1];
      src_data[i] = data_q[i-1];
    end
  end

  // A ready stage either takes its source word or empties; data holds when nothing arrives.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      if (rdy[i]) begin
        vld_d[i] = src_vld[i];
        if (src_vld[i]) data_d[i] = src_data[i];
      end
    end
  end

  assign accept  = in_vld & in_rdy;
  assign consume = vld_q[NUM_STAGES-1] & out_rdy;

  always_comb begin
    count_d = count_q;
    unique case ({accept, consume})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      data_q  <= {NUM_STAGES{RST_DATA}};
      count_q <= '0;
    end else if (flush) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign out_vld  = vld_q[NUM_STAGES-1];
  assign out_data = data_q[NUM_STAGES-1];
  assign count    = count_q;

endmodule

// File: tb/tb_dl_pipe_reg_vr.sv
// Directed bench for dl_pipe_reg_vr (N=3, 8-bit); adds an N=2 skid instance when
// DL_PIPE_REG_VR_SKID_EN is defined.
module tb_dl_pipe_reg_vr;

`ifdef DL_PIPE_REG_VR_SKID_EN
  localparam bit Skid = 1'b1;
`else
  localparam bit Skid = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, flush, in_vld, in_rdy, out_vld, out_rdy;
  logic [7:0] in_data, out_data;
  logic [2:0] count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dl_pipe_reg_vr #(
    .NUM_BITS   (8),
    .NUM_STAGES (3),
    .RST_DATA   (8'h5A)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .count    (count)
  );

`ifdef DL_PIPE_REG_VR_SKID_EN
  logic       s_rst, s_flush, s_in_vld, s_in_rdy, s_out_vld, s_out_rdy;
  logic [7:0] s_in_data, s_out_data;
  logic [1:0] s_count;

  dl_pipe_reg_vr #(
    .NUM_BITS   (8),
    .NUM_STAGES (2),
    .RST_DATA   (8'h00)
  ) u_skid (
    .clk      (clk),
    .rst      (s_rst),
    .flush    (s_flush),
    .in_vld   (s_in_vld),
    .in_rdy   (s_in_rdy),
    .in_data  (s_in_data),
    .out_vld  (s_out_vld),
    .out_rdy  (s_out_rdy),
    .out_data (s_out_data),
    .count    (s_count)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_vld = 1'b0; in_data = 8'h00; out_rdy = 1'b1;
`ifdef DL_PIPE_REG_VR_SKID_EN
    s_rst = 1'b1; s_flush = 1'b0; s_in_vld = 1'b0; s_in_data = 8'h00; s_out_rdy = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
`ifdef DL_PIPE_REG_VR_SKID_EN
    s_rst = 1'b0;
`endif
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, 32'h5A);
    chk("rst_count", count, 0);
    tick();
    chk("rst_in_rdy", in_rdy, 1);

    // Streaming at full rate: word accepted at edge j-2 shows up after edge j.
    out_rdy = 1'b1;
    for (int j = 0; j < 8; j++) begin
      in_vld  = 1'b1;
      in_data = 8'(j + 1);
      chk("stream_in_rdy", in_rdy, 1);
      tick();
      chk("stream_count", count, (j >= 2) ? 3 : j + 1);
      if (j >= 2) begin
        chk("stream_out_vld", out_vld, 1);
        chk("stream_out_data", out_data, 32'(j - 1));
      end
    end
    in_vld = 1'b0;
    for (int j = 8; j < 10; j++) begin
      tick();
      chk("stream_tail_data", out_data, 32'(j - 1));
    end
    tick();
    chk("stream_empty_vld", out_vld, 0);
    chk("stream_empty_count", count, 0);

    // Fill under back-pressure, then a single consume with a simultaneous accept.
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_data = 8'h0A; tick();
    in_data = 8'h0B; tick();
    in_data = 8'h0C; tick();
    in_vld  = 1'b0;
    #1;
    chk("fill_count", count, 3);
    chk("fill_out_vld", out_vld, 1);
    chk("fill_out_data", out_data, 32'h0A);
    chk("fill_in_rdy", in_rdy, Skid ? 1 : 0);
    tick();
    chk("stall_out_data", out_data, 32'h0A);
    chk("stall_out_vld", out_vld, 1);
    out_rdy = 1'b1;
    in_vld  = 1'b1;
    in_data = 8'h0D;
    #1;
    chk("pop_in_rdy", in_rdy, 1);
    tick();
    in_vld  = 1'b0;
    chk("pop_count", count, 3);
    chk("pop_out_data", out_data, 32'h0B);
    tick(); tick(); tick();
    chk("drain_out_vld", out_vld, 0);
    chk("drain_count", count, 0);

    // Single word collapses through empty stages while the output is stalled.
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_data = 8'h05;
    tick();
    in_vld = 1'b0;
    tick();
    chk("collapse_early_vld", out_vld, 0);
    tick();
    chk("collapse_out_vld", out_vld, 1);
    chk("collapse_out_data", out_data, 32'h05);
    chk("collapse_count", count, 1);

    // Flush with a word offered in the same cycle.
    in_vld  = 1'b1;
    in_data = 8'h06;
    tick();
    chk("pre_flush_count", count, 2);
    flush   = 1'b1;
    in_data = 8'hEE;
    tick();
    flush  = 1'b0;
    in_vld = 1'b0;
    chk("flush_out_vld", out_vld, 0);
    chk("flush_count", count, 0);
    chk("flush_data_kept", out_data, 32'h05);
    out_rdy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("flush_no_ghost", out_vld, 0);
    end

    // Reset, then reset together with flush, each with two words held.
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_vld  = 1'b0;
    chk("pre_rst_count", count, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_vld", out_vld, 0);
    chk("midrst_out_data", out_data, 32'h5A);
    chk("midrst_count", count, 0);
    in_vld  = 1'b1;
    in_data = 8'h33; tick();
    in_data = 8'h44; tick();
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    tick();
    tick();
    chk("pre_rstfl_out_data", out_data, 32'h44);
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_data = 8'h55; tick();
    in_data = 8'h66; tick();
    in_vld  = 1'b0;
    rst   = 1'b1;
    flush = 1'b1;
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    chk("rstfl_out_vld", out_vld, 0);
    chk("rstfl_out_data", out_data, 32'h5A);
    chk("rstfl_count", count, 0);

`ifdef DL_PIPE_REG_VR_SKID_EN
    // N=2 with skid: three words fit under back-pressure, in_rdy reacts a cycle late.
    s_out_rdy = 1'b0;
    s_in_vld  = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      s_in_data = 8'(j);
      #1;
      chk("skid_push_in_rdy", s_in_rdy, 1);
      tick();
    end
    s_in_vld = 1'b0;
    chk("skid_full_count", s_count, 3);
    chk("skid_full_in_rdy", s_in_rdy, 0);
    chk("skid_out_first", s_out_data, 32'h01);
    s_out_rdy = 1'b1;
    #1;
    chk("skid_same_cycle_in_rdy", s_in_rdy, 0);
    tick();
    chk("skid_late_in_rdy", s_in_rdy, 1);
    chk("skid_out_second", s_out_data, 32'h02);
    chk("skid_count_2", s_count, 2);
    tick();
    chk("skid_out_third", s_out_data, 32'h03);
    chk("skid_count_1", s_count, 1);
    tick();
    chk("skid_empty_vld", s_out_vld, 0);
    chk("skid_empty_count", s_count, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dl_pipe_reg_vr.md
Name: dl_pipe_reg_vr

Overview:
- Parametrised multi-stage pipeline register with valid/ready flow control, per-stage bubble collapsing, synchronous flush and an occupancy count.
- Successor to the plain enable register. The per-stage enable is derived internally from the handshake rather than driven externally.
- Used between RISC-V pipeline stages and on retiming paths that need back-pressure.

Parameters:
- NUM_BITS, 32, payload width per stage.
- NUM_STAGES, 2, number of register stages (>=1). Sets in-to-out latency.
- RST_DATA, 0, reset value loaded into every stage's data register (NUM_BITS wide).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- flush  input  1  synchronous clear of all valid state; data registers keep their contents.
- in_vld  input  1  upstream word valid.
- in_rdy  output  1  block can accept a word this cycle.
- in_data  input  NUM_BITS  upstream payload.
- out_vld  output  1  last stage holds a valid word.
- out_rdy  input  1  downstream accepts this cycle.
- out_data  output  NUM_BITS  payload of the last stage.
- count  output  $clog2(NUM_STAGES+2)  number of valid words held, including the skid entry when present.

Behaviour:
- State per stage i (0..NUM_STAGES-1): vld[i] and data[i]. out_vld = vld[N-1] and out_data = data[N-1].
- Stage ready: rdy[N-1] = !vld[N-1] | out_rdy. For i<N-1: rdy[i] = !vld[i] | rdy[i+1]. Bubbles collapse; a word advances into any empty downstream stage even while the output stalls.
- Transfer into stage i occurs when rdy[i] is high and the source is valid. The source is stage i-1, or the input for i=0.
  - On transfer: vld[i] <= 1 and data[i] <= source data.
  - When stage i drains with no incoming word: vld[i] <= 0 and data[i] holds.
- Input accepted when in_vld & in_rdy. Output consumed when out_vld & out_rdy.
- Latency: a word accepted at edge t, with no stall, is presented on out_vld during the cycle after edge t+N-1, i.e. N cycles. Throughput is 1 word/cycle while out_rdy stays high.
- Data stability: while out_vld=1 and out_rdy=0, out_data and out_vld hold constant. No word is dropped or duplicated.
- count: registered. Increments on accept without consume, decrements on consume without accept, holds on both or neither. Range is 0..N, or 0..N+1 with skid.
- Reset (rst=1): all vld<=0, all data<=RST_DATA, count<=0. Consequently out_vld=0 and out_data=RST_DATA from the next cycle. in_rdy=1 one cycle after reset deasserts. Reset mid-stream discards all held words.
- Flush (flush=1, rst=0): all vld<=0 and count<=0. An in_vld word presented in the same cycle is NOT captured; in_rdy is still driven, so upstream must treat a flush cycle as a discard. Flush takes priority over simultaneous accept and consume.
- rst takes priority over flush.
- N=1 degenerates to a single full-throughput register whose in_rdy = !vld | out_rdy.

Optional Feature:
- Macro: DL_PIPE_REG_VR_SKID_EN.
- Without the macro: in_rdy = rdy[0]. This is combinational from out_rdy through all stages.
- With the macro: a one-entry skid register (skid_vld, skid_data) sits in front of stage 0.
  - in_rdy = !skid_vld, which is a registered output. No combinational path exists from out_rdy to in_rdy.
  - Source for stage 0 is the skid entry if skid_vld=1, otherwise the input.
  - An accepted input that cannot enter stage 0 that cycle is captured into skid.
  - Skid drains into stage 0 when rdy[0]=1.
  - Capacity is N+1. Latency and throughput are unchanged while the skid is empty.
  - rst and flush clear skid_vld. count includes the skid entry.

Test Plan:
- N=3, out_rdy=1: stream in_data 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 on consecutive cycles, first word 3 cycles after acceptance, in_rdy held 1, count steady at 3.
- N=3: fill with 0xA,0xB,0xC while out_rdy=0 -> count=3, in_rdy=0, out_data=0xA stable. Then raise out_rdy for one cycle -> 0xA consumed, count stays 3 if in_vld delivers 0xD, out_data=0xB next.
- N=3, out_rdy=0: send 0x5 then idle 2 cycles -> word collapses to stage 2, out_vld=1 after 3 cycles, count=1.
- Mid-stream flush with in_vld=1, in_data=0xEE: all valids clear next cycle, count=0, out_vld=0, 0xEE never appears at output.
- rst asserted with 2 words held: next cycle out_vld=0, out_data=RST_DATA, count=0. Asserting flush with rst gives the same result.
- SKID_EN, N=2: out_rdy=0, push 0x1,0x2,0x3 -> all accepted, count=3, in_rdy=0 the following cycle. Toggle out_rdy and in_rdy changes only one cycle later, never in the same cycle. Output order is 0x1,0x2,0x3.
